// File: rtl/dpi_pkt_dispatcher_pkg.sv
// Shared definitions for the DPI packet dispatcher.
//   state_e     : dispatcher FSM states
//   N_STREAMS   : number of stream slots in the flow-key table
//   STREAM_ID_W : width of a stream slot index
//   WAIT_CYCLES : cycles between matcher state restore and the first character
package dpi_pkt_dispatcher_pkg;

  localparam int N_STREAMS   = 64;
  localparam int STREAM_ID_W = 6;
  localparam int WAIT_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    LOAD,
    WAIT,
    STREAM,
    DRAIN,
    EOP,
    RESULT
  } state_e;

endpackage

// File: rtl/dpi_stream_table.sv
// Flow-key table: maps a packet's flow key onto one of N_STREAMS stream slots.
// A lookup request compares key_in against every valid entry in parallel.
// On a hit the matching slot is returned; on a miss the lowest free slot is
// allocated, or the round-robin victim when the table is full. The response
// (rsp_vld pulse, rsp_hit, rsp_new, rsp_index) appears one cycle after the
// request; rsp_hit/rsp_new/rsp_index then hold until the next request.
//   clk, rst   : clock, synchronous active-high reset
//   lookup_req : one-cycle lookup strobe
//   key_in     : flow key to look up (valid with lookup_req)
//   rsp_vld    : response strobe, one cycle after lookup_req
//   rsp_hit    : key was already present
//   rsp_new    : slot was freshly allocated
//   rsp_index  : stream slot for the key
module dpi_stream_table
  import dpi_pkt_dispatcher_pkg::*;
#(
  parameter int KEY_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_req,
  input  logic [KEY_W-1:0]       key_in,
  output logic                   rsp_vld,
  output logic                   rsp_hit,
  output logic                   rsp_new,
  output logic [STREAM_ID_W-1:0] rsp_index
);

  // NOTE: key storage has no reset; an entry is meaningless until its valid
  // bit is set, so only the valid bits are cleared.
  logic [KEY_W-1:0]       key_mem [N_STREAMS];
  logic [N_STREAMS-1:0]   vld_q, vld_d;
  logic [STREAM_ID_W-1:0] victim_q, victim_d;
  logic [STREAM_ID_W-1:0] index_q, index_d;
  logic                   hit_q, hit_d;
  logic                   new_q, new_d;
  logic                   rsp_vld_q, rsp_vld_d;

  logic                   any_hit, any_free;
  logic [STREAM_ID_W-1:0] hit_idx, free_idx;

  // Parallel compare and free-slot search. Scanning from the top down lets the
  // lowest index win.
  always_comb begin
    any_hit  = 1'b0;
    any_free = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = N_STREAMS - 1; i >= 0; i--) begin
      if (vld_q[i] && (key_mem[i] == key_in)) begin
        any_hit = 1'b1;
        hit_idx = STREAM_ID_W'(i);
      end
      if (!vld_q[i]) begin
        any_free = 1'b1;
        free_idx = STREAM_ID_W'(i);
      end
    end
  end

  // NOTE: every variable gets a default before any branch, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    vld_d     = vld_q;
    victim_d  = victim_q;
    index_d   = index_q;
    hit_d     = hit_q;
    new_d     = new_q;
    rsp_vld_d = 1'b0;
    if (lookup_req) begin
      rsp_vld_d = 1'b1;
      if (any_hit) begin
        index_d = hit_idx;
        hit_d   = 1'b1;
        new_d   = 1'b0;
      end else begin
        hit_d = 1'b0;
        new_d = 1'b1;
        if (any_free) begin
          index_d = free_idx;
        end else begin
          // Table full: evict the victim; the pointer wraps at N_STREAMS.
          index_d  = victim_q;
          victim_d = victim_q + 1'b1;
        end
        vld_d[index_d] = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      victim_q  <= '0;
      index_q   <= '0;
      hit_q     <= 1'b0;
      new_q     <= 1'b0;
      rsp_vld_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      victim_q  <= victim_d;
      index_q   <= index_d;
      hit_q     <= hit_d;
      new_q     <= new_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lookup_req && !any_hit) begin
      key_mem[index_d] <= key_in;
    end
  end

  assign rsp_vld   = rsp_vld_q;
  assign rsp_hit   = hit_q;
  assign rsp_new   = new_q;
  assign rsp_index = index_q;

endmodule

// File: rtl/dpi_pkt_dispatcher.sv
// DPI packet dispatcher: accepts a byte stream of packets, assigns each packet
// a stream slot from its flow key, restores the regex matchers for that slot,
// forwards the bytes, and returns the per-matcher fired flags as a result.
//   clk, rst          : clock, synchronous active-high reset
//   in_data/in_vld/in_sop/in_eop/in_key, in_ready : upstream byte stream
//   cfg_enable        : per-matcher enable, captured when matchers are loaded
//   load_state        : pulse telling matchers to restore slot state
//   stream_id         : stream slot of the current packet
//   new_stream_id     : slot was freshly allocated (matchers start at state 0)
//   char_in/char_in_vld : registered byte stream to the matchers
//   eop               : packet-end pulse to the matchers
//   enable            : captured cfg_enable, held for the packet
//   fired             : per-matcher match flags
//   res_vld/res_ready/res_stream/res_fired : result handshake
module dpi_pkt_dispatcher
  import dpi_pkt_dispatcher_pkg::*;
#(
  parameter int N_REGEX   = 16,
  parameter int KEY_W     = 32,
  parameter int MATCH_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_vld,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [KEY_W-1:0]       in_key,
  output logic                   in_ready,
  input  logic [N_REGEX-1:0]     cfg_enable,
  output logic                   load_state,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic                   new_stream_id,
  output logic [7:0]             char_in,
  output logic                   char_in_vld,
  output logic                   eop,
  output logic [N_REGEX-1:0]     enable,
  input  logic [N_REGEX-1:0]     fired,
  output logic                   res_vld,
  input  logic                   res_ready,
  output logic [STREAM_ID_W-1:0] res_stream,
  output logic [N_REGEX-1:0]     res_fired
);

  localparam logic [7:0] WAIT_LAST  = 8'(WAIT_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(MATCH_LAT - 1);

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [KEY_W-1:0]       key_q, key_d;
  logic                   first_q, first_d;
  logic [7:0]             char_in_q, char_in_d;
  logic                   char_vld_q, char_vld_d;
  logic [N_REGEX-1:0]     enable_q, enable_d;
  logic [STREAM_ID_W-1:0] res_stream_q, res_stream_d;
  logic [N_REGEX-1:0]     res_fired_q, res_fired_d;
  logic [15:0]            err_cnt_q, err_cnt_d;

  logic                   in_ready_c, load_state_c, eop_c, res_vld_c;
  logic                   lookup_req, err_inc;
  logic                   tbl_rsp_vld, tbl_hit, tbl_new;
  logic [STREAM_ID_W-1:0] tbl_index;

  dpi_stream_table #(
    .KEY_W (KEY_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .lookup_req (lookup_req),
    .key_in     (key_q),
    .rsp_vld    (tbl_rsp_vld),
    .rsp_hit    (tbl_hit),
    .rsp_new    (tbl_new),
    .rsp_index  (tbl_index)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    first_d      = first_q;
    char_in_d    = char_in_q;
    char_vld_d   = 1'b0;
    enable_d     = enable_q;
    res_stream_d = res_stream_q;
    res_fired_d  = res_fired_q;
    err_cnt_d    = err_cnt_q;
    in_ready_c   = 1'b0;
    load_state_c = 1'b0;
    eop_c        = 1'b0;
    res_vld_c    = 1'b0;
    lookup_req   = 1'b0;
    err_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_vld) begin
          if (in_sop) begin
            // Latch the key but leave the sop byte pending for STREAM.
            key_d   = in_key;
            state_d = LOOKUP;
          end else begin
            // A byte outside any packet is swallowed and counted.
            in_ready_c = 1'b1;
            err_inc    = 1'b1;
          end
        end
      end
      LOOKUP: begin
        lookup_req = 1'b1;
        state_d    = LOAD;
      end
      LOAD: begin
        if (tbl_rsp_vld) begin
          load_state_c = 1'b1;
          enable_d     = cfg_enable;
          first_d      = 1'b1;
          cnt_d        = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = STREAM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STREAM: begin
        in_ready_c = 1'b1;
        if (in_vld) begin
          char_in_d  = in_data;
          char_vld_d = 1'b1;
          first_d    = 1'b0;
          if (in_sop && !first_q) err_inc = 1'b1;
          if (in_eop) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Give the matchers MATCH_LAT cycles to fold in the last character.
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = EOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      EOP: begin
        eop_c        = 1'b1;
        res_fired_d  = fired & enable_q;
        res_stream_d = tbl_index;
        state_d      = RESULT;
      end
      RESULT: begin
        res_vld_c = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_inc && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      key_q        <= '0;
      first_q      <= 1'b0;
      char_in_q    <= '0;
      char_vld_q   <= 1'b0;
      enable_q     <= '0;
      res_stream_q <= '0;
      res_fired_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      first_q      <= first_d;
      char_in_q    <= char_in_d;
      char_vld_q   <= char_vld_d;
      enable_q     <= enable_d;
      res_stream_q <= res_stream_d;
      res_fired_q  <= res_fired_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // State-decoded strobes are forced low while reset is held so nothing is
  // accepted or issued during the reset cycle itself.
  assign in_ready      = in_ready_c   & ~rst;
  assign load_state    = load_state_c & ~rst;
  assign eop           = eop_c        & ~rst;
  assign res_vld       = res_vld_c    & ~rst;
  assign stream_id     = tbl_index;
  assign new_stream_id = tbl_new & ~tbl_hit;
  assign char_in       = char_in_q;
  assign char_in_vld   = char_vld_q;
  assign enable        = enable_q;
  assign res_stream    = res_stream_q;
  assign res_fired     = res_fired_q;

endmodule

// File: doc/dpi_pkt_dispatcher.md
DPI_PKT_DISPATCHER -- requirements
Module: dpi_pkt_dispatcher

Interface
REQ-001 Parameters SHALL be: N_REGEX, default 16, number of matcher instances driven; KEY_W, default 32, flow-key width; MATCH_LAT, default 2, matcher char-to-fired latency in cycles.
REQ-002 Ports SHALL be as follows. The design SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  8  packet byte
in_vld  in  1  byte valid
in_sop  in  1  first byte of packet; qualifies in_key
in_eop  in  1  last byte of packet
in_key  in  KEY_W  flow key, valid with in_sop
in_ready  out  1  byte accepted when in_vld&in_ready
cfg_enable  in  N_REGEX  per-matcher enable, sampled at load
load_state  out  1  one-cycle pulse: matchers restore state
stream_id  out  6  stream slot for current packet
new_stream_id  out  1  slot freshly allocated; matchers start from state 0
char_in  out  8  byte to matchers
char_in_vld  out  1  byte valid to matchers
eop  out  1  one-cycle packet-end pulse to matchers
enable  out  N_REGEX  registered cfg_enable, held for the packet
fired  in  N_REGEX  per-matcher match flags
res_vld  out  1  result valid
res_ready  in  1  result accepted
res_stream  out  6  stream_id of result
res_fired  out  N_REGEX  fired&enable sampled on eop cycle

Function
REQ-003 FSM states SHALL be IDLE, LOOKUP, LOAD, WAIT, STREAM, DRAIN, EOP, RESULT.
REQ-004 IDLE: on in_vld&in_sop, the block SHALL latch in_key without consuming the byte (in_ready=0) and go to LOOKUP; in_vld without in_sop SHALL be consumed, dropped, and increment err_cnt.
REQ-005 LOOKUP (1 cycle): the block SHALL compare the key against all 64 valid key-table entries in parallel; on a hit, stream_id=hit index and new_stream_id=0; on a miss, stream_id=first invalid slot, or the round-robin victim pointer if all are valid (pointer then increments mod 64); the entry SHALL be written, marked valid, and new_stream_id=1.
REQ-006 LOAD (1 cycle): load_state=1, and enable<=cfg_enable.
REQ-007 WAIT SHALL last exactly 2 cycles so the matcher restored state is valid before the first character.
REQ-008 STREAM: in_ready=1; each accepted beat SHALL drive char_in=in_data with char_in_vld=1 on the next cycle (1-cycle register); in_sop on a non-first beat SHALL be ignored and increment err_cnt; an accepted in_eop beat SHALL move to DRAIN.
REQ-009 DRAIN SHALL last MATCH_LAT cycles with char_in_vld=0 and in_ready=0.
REQ-010 EOP (1 cycle): eop=1; res_fired<=fired&enable; res_stream<=stream_id.
REQ-011 RESULT: res_vld=1, with res_* held stable until res_vld&res_ready, then go to IDLE; in_ready=0 throughout.
REQ-012 Outside STREAM, in_ready SHALL be 0; load_state, eop, and char_in_vld SHALL never be high in the same cycle.
REQ-013 stream_id and enable SHALL be held constant from LOAD through EOP.
REQ-014 A single-beat packet (in_sop&in_eop) SHALL produce exactly one char_in_vld pulse, then DRAIN and EOP.
REQ-015 err_cnt SHALL be an internal 16-bit counter that saturates at 0xFFFF and is readable only via hierarchy.

Reset
REQ-016 While rst=1: FSM=IDLE; all key-table valid bits=0; victim pointer=0; err_cnt=0; outputs in_ready, load_state, new_stream_id, char_in_vld, eop, and res_vld=0; stream_id, char_in, enable, res_stream, and res_fired=0.
REQ-017 Reset asserted mid-packet SHALL abort the packet with no eop and no result; the upstream SHALL resend from sop.

Structure
REQ-018 A shared package SHALL hold: the FSM state enum; the constants N_STREAMS=64, STREAM_ID_W=6, and WAIT_CYCLES=2.
REQ-019 The key table plus parallel compare and allocation SHALL be a sub-module, dpi_stream_table (lookup request, key in, then hit, index, new out, valid one cycle later).

Verification
REQ-020 Key 0xA5A5A5A5, 4-byte packet after reset -> new_stream_id=1, stream_id=0, load_state pulse, 4 char_in_vld beats starting 4 cycles after sop accepted, eop 2 cycles after last char, res_stream=0.
REQ-021 Same key again -> new_stream_id=0, stream_id=0; a second distinct key -> stream_id=1, new_stream_id=1.
REQ-022 65 distinct keys -> 65th allocated stream_id=0 (victim), new_stream_id=1; original key 0xA5A5A5A5 then misses.
REQ-023 cfg_enable=0x0003, fired=0x0007 forced on eop -> res_fired=0x0003; res_ready held low 10 cycles -> res_vld and res_* stable, in_ready=0.
REQ-024 Single-beat packet; then a stray in_vld without sop in IDLE -> one char_in_vld; err_cnt=1; no load_state for the stray byte.
REQ-025 Assert rst during STREAM after 2 beats -> next cycle all outputs at reset values; no eop ever issued for that packet.
